// File: rtl/mem_sched_wrr.sv
// Shares one burst-capable memory port among NCLIENTS masters: round-robin grants with a bounded
// sticky repeat for the last owner; the owner keeps the port until its whole burst has completed.
module mem_sched_wrr #(
  parameter int NCLIENTS       = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 2,
  parameter int MAX_CONSEC     = 2
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NCLIENTS*ADDR_WIDTH-1:0]     c_addr,
  input  logic [NCLIENTS*BURSTLEN_WIDTH-1:0] c_burst_len,
  input  logic [NCLIENTS*DATA_WIDTH-1:0]     c_wr_data,
  input  logic [NCLIENTS-1:0]                c_rd,
  input  logic [NCLIENTS-1:0]                c_wr,
  output logic [NCLIENTS-1:0]                c_waitrequest,
  output logic [NCLIENTS-1:0]                c_rd_valid,
  output logic [DATA_WIDTH-1:0]              c_rd_data,
  output logic [ADDR_WIDTH-1:0]              mm_addr,
  output logic [BURSTLEN_WIDTH-1:0]          mm_burst_len,
  output logic [DATA_WIDTH-1:0]              mm_wr_data,
  output logic                               mm_rd,
  output logic                               mm_wr,
  input  logic                               mm_waitrequest,
  input  logic                               mm_rd_valid,
  input  logic [DATA_WIDTH-1:0]              mm_rd_data
);
  localparam int IW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam logic [NCLIENTS-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_DATA} state_t;

  state_t                    state, state_nxt;
  logic [IW-1:0]             owner, owner_nxt, last, last_nxt, pick;
  logic [CW-1:0]             consec, consec_nxt;
  logic [BURSTLEN_WIDTH-1:0] beat, beat_nxt, blen, blen_nxt;
  logic [NCLIENTS-1:0]       req;
  logic                      pick_last, found;
  int                        idx;

  logic [ADDR_WIDTH-1:0]     addr_a [NCLIENTS];
  logic [DATA_WIDTH-1:0]     data_a [NCLIENTS];
  logic [BURSTLEN_WIDTH-1:0] len_a  [NCLIENTS];

  always_comb begin
    for (int i = 0; i < NCLIENTS; i++) begin
      addr_a[i] = c_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_a[i] = c_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      len_a[i]  = c_burst_len[i*BURSTLEN_WIDTH +: BURSTLEN_WIDTH];
    end
  end

  assign req = c_rd | c_wr;

  // Sticky repeat unless the budget is spent and someone else is waiting; else scan from last+1.
  always_comb begin
    pick      = last;
    found     = 1'b0;
    idx       = 0;
    pick_last = req[last] && ((consec < CW'(MAX_CONSEC)) || (req == (ONE << last)));
    for (int k = 1; k <= NCLIENTS; k++) begin
      idx = (int'(last) + k) % NCLIENTS;
      if (!found && req[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    if (pick_last) pick = last;
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    last_nxt   = last;
    consec_nxt = consec;
    beat_nxt   = beat;
    blen_nxt   = blen;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt  = pick;
          last_nxt   = pick;
          blen_nxt   = len_a[pick];
          beat_nxt   = '0;
          if (pick_last)
            consec_nxt = (consec == CW'(MAX_CONSEC)) ? consec : consec + 1'b1;
          else
            consec_nxt = CW'(1);
          state_nxt  = c_wr[pick] ? WR_DATA : RD_CMD;
        end
      end
      RD_CMD: begin
        if (!c_rd[owner]) begin
          state_nxt = IDLE;
        end else if (!mm_waitrequest) begin
          state_nxt = RD_DATA;
          beat_nxt  = '0;
        end
      end
      RD_DATA: begin
        if (mm_rd_valid) begin
          if (beat == blen) state_nxt = IDLE;
          else              beat_nxt  = beat + 1'b1;
        end
      end
      WR_DATA: begin
        if (mm_wr && !mm_waitrequest) begin
          if (beat == blen) state_nxt = IDLE;
          else              beat_nxt  = beat + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= '0;
      last   <= IW'(NCLIENTS - 1);
      consec <= '0;
      beat   <= '0;
      blen   <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      last   <= last_nxt;
      consec <= consec_nxt;
      beat   <= beat_nxt;
      blen   <= blen_nxt;
    end
  end

  // An owner exists only outside IDLE; the data path reads zero otherwise.
  assign mm_addr      = (state != IDLE) ? addr_a[owner] : '0;
  assign mm_wr_data   = (state != IDLE) ? data_a[owner] : '0;
  assign mm_burst_len = (state != IDLE) ? len_a[owner]  : '0;
  assign mm_rd        = (state == RD_CMD)  && c_rd[owner];
  assign mm_wr        = (state == WR_DATA) && c_wr[owner];
  assign c_rd_data    = mm_rd_data;

  always_comb begin
    for (int i = 0; i < NCLIENTS; i++) begin
      c_waitrequest[i] = !((owner == IW'(i)) && ((state == RD_CMD) || (state == WR_DATA)))
                         || mm_waitrequest;
      c_rd_valid[i]    = (state == RD_DATA) && mm_rd_valid && (owner == IW'(i));
    end
  end
endmodule

// File: tb/tb_mem_sched_wrr.sv
// Random multi-client traffic against a transaction-level arbitration model; a monitor checks
// every memory command, write beat and routed read beat against a queue of expected bursts.
module tb_mem_sched_wrr;
  localparam int N = 3, AW = 32, DW = 32, BW = 2, MAXC = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic [N*AW-1:0]   c_addr;
  logic [N*BW-1:0]   c_burst_len;
  logic [N*DW-1:0]   c_wr_data;
  logic [N-1:0]      c_rd, c_wr, c_waitrequest, c_rd_valid;
  logic [DW-1:0]     c_rd_data, mm_wr_data, mm_rd_data;
  logic [AW-1:0]     mm_addr;
  logic [BW-1:0]     mm_burst_len;
  logic              mm_rd, mm_wr, mm_waitrequest, mm_rd_valid;

  always #5 clock = ~clock;

  mem_sched_wrr #(.NCLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .BURSTLEN_WIDTH(BW), .MAX_CONSEC(MAXC)) dut (
    .clock(clock), .reset_n(reset_n), .c_addr(c_addr), .c_burst_len(c_burst_len),
    .c_wr_data(c_wr_data), .c_rd(c_rd), .c_wr(c_wr), .c_waitrequest(c_waitrequest),
    .c_rd_valid(c_rd_valid), .c_rd_data(c_rd_data), .mm_addr(mm_addr),
    .mm_burst_len(mm_burst_len), .mm_wr_data(mm_wr_data), .mm_rd(mm_rd), .mm_wr(mm_wr),
    .mm_waitrequest(mm_waitrequest), .mm_rd_valid(mm_rd_valid), .mm_rd_data(mm_rd_data));

  typedef struct packed {
    logic [2:0]           cl;
    logic                 w;
    logic [AW-1:0]        addr;
    logic [BW-1:0]        len;
    logic [3:0][DW-1:0]   d;
  } exp_t;

  exp_t expq[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Client intents and the burst-level reference model.
  bit                 pend [N];
  bit                 dirw [N];
  logic [AW-1:0]      caddr[N];
  logic [BW-1:0]      clen [N];
  logic [3:0][DW-1:0] cdata[N];
  int phase, cur, m_last, m_consec, wbeat, rd_left, mem_delay;

  function automatic int arb();
    int others = 0;
    for (int i = 0; i < N; i++) if (pend[i] && i != m_last) others++;
    if (pend[m_last] && (m_consec < MAXC || others == 0)) return m_last;
    for (int k = 1; k <= N; k++) if (pend[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic new_req(input int i, input bit w, input logic [27:0] a, input logic [BW-1:0] len);
    pend[i]  = 1'b1;
    dirw[i]  = w;
    caddr[i] = {4'(i), a};
    clen[i]  = len;
    for (int b = 0; b < 4; b++) cdata[i][b] = $urandom;
  endtask

  task automatic model_reset();
    phase = 0; cur = 0; m_last = N - 1; m_consec = 0; wbeat = 0; rd_left = 0; mem_delay = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    expq.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      c_rd[i] = pend[i] && !dirw[i];
      c_wr[i] = pend[i] && dirw[i];
      c_addr[i*AW +: AW]      = caddr[i];
      c_burst_len[i*BW +: BW] = clen[i];
      c_wr_data[i*DW +: DW]   = (phase == 3 && cur == i) ? cdata[i][wbeat] : cdata[i][0];
    end
    mm_waitrequest = ($urandom_range(0, 2) == 0);
    mm_rd_data     = $urandom;
    mm_rd_valid    = 1'b0;
    if (phase == 2) begin
      if (mem_delay > 0) mem_delay--;
      else mm_rd_valid = ($urandom_range(0, 3) != 0);
    end else begin
      mm_rd_valid = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Advances the model by what the coming clock edge does with the inputs just driven.
  task automatic sample();
    int   w;
    exp_t e;
    if (phase == 0) begin
      w = arb();
      if (w >= 0) begin
        if (w == m_last) m_consec++; else m_consec = 1;
        m_last = w; cur = w; wbeat = 0;
        e.cl = 3'(w); e.w = dirw[w]; e.addr = caddr[w]; e.len = clen[w]; e.d = cdata[w];
        expq.push_back(e);
        phase = dirw[w] ? 3 : 1;
      end
    end else if (phase == 1) begin
      if (!mm_waitrequest) begin
        phase = 2; rd_left = int'(clen[cur]) + 1; mem_delay = $urandom_range(0, 2);
      end
    end else if (phase == 2) begin
      if (mm_rd_valid) begin
        rd_left--;
        if (rd_left == 0) begin phase = 0; pend[cur] = 1'b0; end
      end
    end else if (!mm_waitrequest) begin
      wbeat++;
      if (wbeat > int'(clen[cur])) begin phase = 0; pend[cur] = 1'b0; end
    end
  endtask

  task automatic step(input bit allow_new);
    @(negedge clock);
    if (allow_new)
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 0)
          new_req(i, 1'($urandom_range(0, 1)), 28'($urandom), BW'($urandom_range(0, 3)));
    drive();
    #4;
    sample();
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain();
    int n = 0;
    while ((phase != 0 || any_pend()) && n < 400) begin step(0); n++; end
    if (n >= 400) begin
      checks++; failures++;
      $display("FAIL drain: bursts still open after %0d cycles, phase %0d", n, phase);
    end
    chk("queue_empty", expq.size(), 0);
  endtask

  // Monitor: samples just before each rising edge and consumes the expected queue.
  exp_t          mwr_e;
  logic [2:0]    mrd_cl;
  bit            mrd_active = 1'b0;
  bit            mwr_ok = 1'b0;
  int            mrd_left = 0, mwr_beat = 0;
  logic [N-1:0]  one_n = 1;
  logic [N-1:0]  exp_vec;

  always begin
    exp_t e;
    @(negedge clock);
    #4;
    if (!reset_n) begin
      mrd_active = 1'b0; mwr_beat = 0;
    end else begin
      if (mm_rd_valid || c_rd_valid != '0) begin
        if (mrd_active && mm_rd_valid) begin
          exp_vec = one_n << mrd_cl;
          chk("rd_valid_route", c_rd_valid, exp_vec);
          chk("rd_data", c_rd_data, mm_rd_data);
          mrd_left--;
          if (mrd_left == 0) mrd_active = 1'b0;
        end else begin
          chk("rd_valid_ignored", c_rd_valid, '0);
        end
      end
      if (mm_rd && !mm_waitrequest) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_cmd: unexpected read at addr %0h", mm_addr);
        end else begin
          e = expq.pop_front();
          exp_vec = ~(one_n << e.cl);
          chk("cmd_dir", {mm_rd, mm_wr}, e.w ? 2'b01 : 2'b10);
          chk("rd_addr", mm_addr, e.addr);
          chk("rd_len", mm_burst_len, e.len);
          chk("rd_waitreq", c_waitrequest, exp_vec);
          mrd_active = 1'b1; mrd_cl = e.cl; mrd_left = int'(e.len) + 1;
        end
      end
      if (mm_wr && !mm_waitrequest) begin
        if (mwr_beat == 0) begin
          mwr_ok = (expq.size() != 0);
          if (mwr_ok) mwr_e = expq.pop_front();
        end
        if (!mwr_ok) begin
          checks++; failures++;
          $display("FAIL wr_cmd: unexpected write at addr %0h", mm_addr);
        end else begin
          exp_vec = ~(one_n << mwr_e.cl);
          chk("cmd_dir", {mm_rd, mm_wr}, mwr_e.w ? 2'b01 : 2'b10);
          chk("wr_addr", mm_addr, mwr_e.addr);
          chk("wr_len", mm_burst_len, mwr_e.len);
          chk("wr_data", mm_wr_data, mwr_e.d[mwr_beat]);
          chk("wr_waitreq", c_waitrequest, exp_vec);
          mwr_beat++;
          if (mwr_beat > int'(mwr_e.len)) mwr_beat = 0;
        end
      end
      if ((mm_rd || mm_wr) && mm_waitrequest) chk("stall_all", c_waitrequest, {N{1'b1}});
    end
  end

  initial begin
    int n;
    c_addr = '0; c_burst_len = '0; c_wr_data = '0; c_rd = '0; c_wr = '0;
    mm_waitrequest = 1'b0; mm_rd_valid = 1'b0; mm_rd_data = '0;
    for (int i = 0; i < N; i++) begin caddr[i] = '0; clen[i] = '0; cdata[i] = '0; dirw[i] = 1'b0; end
    model_reset();

    // Reset held with requests and a stray read beat present.
    #1 reset_n = 1'b0;
    c_rd = '1; c_addr = {N{32'h1234_5678}}; mm_rd_valid = 1'b1;
    #3;
    chk("rst_waitreq", c_waitrequest, {N{1'b1}});
    chk("rst_cmd", {mm_rd, mm_wr}, 2'b00);
    chk("rst_rd_valid", c_rd_valid, '0);
    chk("rst_addr", mm_addr, '0);
    repeat (2) @(negedge clock);
    c_rd = '0; c_addr = '0; mm_rd_valid = 1'b0; reset_n = 1'b1;

    repeat (4) step(0);
    chk("idle_waitreq", c_waitrequest, {N{1'b1}});
    chk("idle_cmd", {mm_rd, mm_wr}, 2'b00);

    new_req(1, 1'b0, 28'h100, 2'd3);
    drain();

    repeat (1500) step(1);
    drain();

    // Reset asserted in the middle of a four-beat read.
    new_req(1, 1'b0, 28'h100, 2'd3);
    n = 0;
    while (!(phase == 2 && rd_left == 2) && n < 200) begin step(0); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL midreset_setup: read never reached beat 2, phase %0d", phase);
    end
    @(negedge clock);
    mm_rd_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("midrst_waitreq", c_waitrequest, {N{1'b1}});
    chk("midrst_cmd", {mm_rd, mm_wr}, 2'b00);
    chk("midrst_rd_valid", c_rd_valid, '0);
    chk("midrst_addr", mm_addr, '0);
    model_reset();
    drive();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    repeat (800) step(1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
